// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B, one bit per clock, LSB first, through one
// full-subtractor cell. Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       fsm_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             br_next;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    assign d        = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        fsm_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            Diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= A;
                        b_sh <= B;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= {d, res_sh[WIDTH-1:1]};
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        Diff <= {d, res_sh[WIDTH-1:1]};
                        bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit the operand LSBs are the captured MSBs.
                        ovf  <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
